// File: rtl/alu_cmd_ctrl.sv
// UART command front-end for an ALU: collects opcode + two little-endian operands,
// issues one ALU request and streams the result (or an error byte) back out.
`timescale 1ns/1ps
module alu_cmd_ctrl #(
   parameter int unsigned OPERAND_WIDTH  = 32,
   parameter int unsigned TIMEOUT_CYCLES = 28000
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic [7:0]               rx_data_i,
   input  logic                     rx_valid_i,
   output logic                     rx_ready_o,
   output logic [7:0]               tx_data_o,
   output logic                     tx_valid_o,
   input  logic                     tx_ready_i,
   output logic [2:0]               alu_op_o,
   output logic [OPERAND_WIDTH-1:0] alu_a_o,
   output logic [OPERAND_WIDTH-1:0] alu_b_o,
   output logic                     alu_valid_o,
   input  logic                     alu_ready_i,
   input  logic [OPERAND_WIDTH-1:0] alu_result_i,
   input  logic                     alu_result_valid_i,
   output logic                     busy_o,
   output logic                     err_o
);

   localparam int unsigned NBYTES = OPERAND_WIDTH / 8;
   localparam int unsigned CNT_W  = $clog2(NBYTES);
   localparam int unsigned IDX_W  = CNT_W + 3;
   localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_RX_A     = 3'd1;
   localparam logic [2:0] S_RX_B     = 3'd2;
   localparam logic [2:0] S_ALU_REQ  = 3'd3;
   localparam logic [2:0] S_ALU_WAIT = 3'd4;
   localparam logic [2:0] S_TX_RES   = 3'd5;
   localparam logic [2:0] S_TX_ERR   = 3'd6;

   logic [2:0]               state_q, state_d;
   logic [7:0]               op_q, op_d;
   logic [OPERAND_WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d, nxt_cnt;
   logic [TMO_W-1:0]         tmo_q, tmo_d;
   logic [7:0]               tx_data_q, tx_data_d;
   logic                     tx_valid_q, tx_valid_d;
   logic                     alu_valid_q, alu_valid_d;
   logic                     busy_q, busy_d;
   logic                     err_q, err_d;
   logic                     rx_acc, tx_acc, last_byte, tmo_hit, op_ok;
   logic [IDX_W-1:0]         byte_idx, nxt_idx;

   // Input is accepted only while collecting a packet.
   assign rx_ready_o = (state_q == S_IDLE) || (state_q == S_RX_A) || (state_q == S_RX_B);

   assign tx_data_o   = tx_data_q;
   assign tx_valid_o  = tx_valid_q;
   assign alu_op_o    = op_q[2:0];
   assign alu_a_o     = a_q;
   assign alu_b_o     = b_q;
   assign alu_valid_o = alu_valid_q;
   assign busy_o      = busy_q;
   assign err_o       = err_q;

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      res_d       = res_q;
      cnt_d       = cnt_q;
      tmo_d       = tmo_q;
      tx_data_d   = tx_data_q;
      tx_valid_d  = tx_valid_q;
      alu_valid_d = alu_valid_q;
      err_d       = 1'b0;
      rx_acc      = rx_valid_i && rx_ready_o;
      tx_acc      = tx_valid_q && tx_ready_i;
      nxt_cnt     = cnt_q + CNT_W'(1);
      byte_idx    = {cnt_q, 3'b000};
      nxt_idx     = {nxt_cnt, 3'b000};
      last_byte   = (cnt_q == CNT_W'(NBYTES - 1));
      tmo_hit     = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
      op_ok       = (op_q[7:3] == 5'd0);

      case (state_q)
         S_IDLE: begin
            if (rx_acc) begin
               op_d    = rx_data_i;
               cnt_d   = '0;
               tmo_d   = '0;
               state_d = S_RX_A;
            end
         end
         S_RX_A, S_RX_B: begin
            if (rx_acc) begin
               tmo_d = '0;
               cnt_d = nxt_cnt;
               if (state_q == S_RX_A) a_d[byte_idx +: 8] = rx_data_i;
               else                   b_d[byte_idx +: 8] = rx_data_i;
               if (last_byte) begin
                  cnt_d = '0;
                  if (state_q == S_RX_A) begin
                     state_d = S_RX_B;
                  end else if (op_ok) begin
                     state_d     = S_ALU_REQ;
                     alu_valid_d = 1'b1;
                  end else begin
                     state_d    = S_TX_ERR;
                     err_d      = 1'b1;
                     tx_data_d  = 8'hEE;
                     tx_valid_d = 1'b1;
                  end
               end
            end else if (tmo_hit) begin
               // Stalled sender: drop the partial packet silently apart from err_o.
               state_d = S_IDLE;
               err_d   = 1'b1;
               a_d     = '0;
               b_d     = '0;
               cnt_d   = '0;
               tmo_d   = '0;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         S_ALU_REQ, S_ALU_WAIT: begin
            if (state_q == S_ALU_REQ && alu_ready_i) begin
               alu_valid_d = 1'b0;
               state_d     = S_ALU_WAIT;
            end
            // Result may arrive in the same cycle the request is accepted.
            if (alu_result_valid_i && (state_q == S_ALU_WAIT || alu_ready_i)) begin
               res_d      = alu_result_i;
               tx_data_d  = alu_result_i[7:0];
               tx_valid_d = 1'b1;
               cnt_d      = '0;
               state_d    = S_TX_RES;
            end
         end
         S_TX_RES: begin
            if (tx_acc) begin
               if (last_byte) begin
                  tx_valid_d = 1'b0;
                  cnt_d      = '0;
                  state_d    = S_IDLE;
               end else begin
                  cnt_d     = nxt_cnt;
                  tx_data_d = res_q[nxt_idx +: 8];
               end
            end
         end
         S_TX_ERR: begin
            if (tx_acc) begin
               tx_valid_d = 1'b0;
               state_d    = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         res_q       <= '0;
         cnt_q       <= '0;
         tmo_q       <= '0;
         tx_data_q   <= '0;
         tx_valid_q  <= 1'b0;
         alu_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         res_q       <= res_d;
         cnt_q       <= cnt_d;
         tmo_q       <= tmo_d;
         tx_data_q   <= tx_data_d;
         tx_valid_q  <= tx_valid_d;
         alu_valid_q <= alu_valid_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
      end
   end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Scoreboard bench for alu_cmd_ctrl: directed packets push expected ALU requests and
// reply bytes into queues; a negedge monitor pops and compares on each handshake.
`timescale 1ns/1ps
module tb_alu_cmd_ctrl;

   localparam int unsigned TMO = 64;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic [7:0]  rx_data_i = '0;
   logic        rx_valid_i = 1'b0;
   logic        rx_ready_o;
   logic [7:0]  tx_data_o;
   logic        tx_valid_o;
   logic        tx_ready_i = 1'b1;
   logic [2:0]  alu_op_o;
   logic [31:0] alu_a_o, alu_b_o;
   logic        alu_valid_o;
   logic        alu_ready_i = 1'b0;
   logic [31:0] alu_result_i = '0;
   logic        alu_result_valid_i = 1'b0;
   logic        busy_o, err_o;

   alu_cmd_ctrl #(.OPERAND_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
      .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
      .alu_op_o(alu_op_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
      .alu_valid_o(alu_valid_o), .alu_ready_i(alu_ready_i),
      .alu_result_i(alu_result_i), .alu_result_valid_i(alu_result_valid_i),
      .busy_o(busy_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
   } alu_req_t;

   logic [7:0] exp_tx[$];
   alu_req_t   exp_alu[$];
   int n_cmp = 0;
   int n_bad = 0;
   int err_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic flag(input string name, input logic [31:0] act);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got %h with nothing expected (t=%0t)", name, act, $time);
   endtask

   // Monitor: pops expectations on handshakes, checks tx hold during stalls, counts err pulses.
   initial begin
      logic       stall_q;
      logic [7:0] stall_data;
      alu_req_t   r;
      stall_q = 1'b0;
      stall_data = '0;
      forever begin
         @(negedge clk);
         if (!rst_ni) begin
            stall_q = 1'b0;
         end else begin
            if (err_o) err_cnt++;
            if (stall_q) begin
               check("tx_hold_valid", 32'(tx_valid_o), 32'd1);
               check("tx_hold_data", 32'(tx_data_o), 32'(stall_data));
            end
            if (tx_valid_o && tx_ready_i) begin
               if (exp_tx.size() == 0) flag("tx_unexpected", 32'(tx_data_o));
               else check("tx_byte", 32'(tx_data_o), 32'(exp_tx.pop_front()));
            end
            stall_q = tx_valid_o && !tx_ready_i;
            stall_data = tx_data_o;
            if (alu_valid_o && exp_alu.size() == 0) begin
               flag("alu_unexpected", 32'(alu_op_o));
            end else if (alu_valid_o && alu_ready_i) begin
               r = exp_alu.pop_front();
               check("alu_op", 32'(alu_op_o), 32'(r.op));
               check("alu_a", alu_a_o, r.a);
               check("alu_b", alu_b_o, r.b);
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit done;
      int k;
      done = 1'b0;
      k = 0;
      rx_data_i = b;
      rx_valid_i = 1'b1;
      while (!done && k < 200) begin
         @(negedge clk);
         done = rx_ready_o;
         @(posedge clk);
         k++;
      end
      #1;
      rx_valid_i = 1'b0;
      if (!done) flag("rx_accept_timeout", 32'(b));
   endtask

   task automatic send_pkt(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
      send_byte(op);
      for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
      for (int i = 0; i < 4; i++) send_byte(b[8*i +: 8]);
   endtask

   task automatic push_res(input logic [31:0] r);
      for (int i = 0; i < 4; i++) exp_tx.push_back(r[8*i +: 8]);
   endtask

   task automatic push_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      alu_req_t r;
      r.op = op;
      r.a = a;
      r.b = b;
      exp_alu.push_back(r);
   endtask

   task automatic alu_respond(input bit same_cycle, input logic [31:0] r);
      int k;
      k = 0;
      while (!alu_valid_o && k < 100) begin
         @(posedge clk);
         #1;
         k++;
      end
      if (!alu_valid_o) begin
         flag("alu_valid_timeout", 32'(k));
      end else begin
         alu_ready_i = 1'b1;
         if (same_cycle) begin
            alu_result_i = r;
            alu_result_valid_i = 1'b1;
         end
         idle(1);
         alu_ready_i = 1'b0;
         alu_result_valid_i = 1'b0;
         if (!same_cycle) begin
            idle(3);
            alu_result_i = r;
            alu_result_valid_i = 1'b1;
            idle(1);
            alu_result_valid_i = 1'b0;
         end
      end
   endtask

   task automatic wait_tx_valid();
      int k;
      k = 0;
      while (!tx_valid_o && k < 100) begin
         @(posedge clk);
         #1;
         k++;
      end
      if (!tx_valid_o) flag("tx_valid_timeout", 32'(k));
   endtask

   task automatic wait_done(input string name);
      int k;
      k = 0;
      while ((busy_o || exp_tx.size() != 0) && k < 500) begin
         @(posedge clk);
         #1;
         k++;
      end
      check({name, "_busy_after"}, 32'(busy_o), 32'd0);
      check({name, "_tx_drained"}, 32'(exp_tx.size()), 32'd0);
   endtask

   initial begin
      int e0;

      // Reset state
      #12;
      check("rst_rx_ready", 32'(rx_ready_o), 32'd0 | 32'd1);
      check("rst_tx_valid", 32'(tx_valid_o), 32'd0);
      check("rst_alu_valid", 32'(alu_valid_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_err", 32'(err_o), 32'd0);
      check("rst_tx_data", 32'(tx_data_o), 32'd0);
      check("rst_alu_a", alu_a_o, 32'd0);
      check("rst_alu_b", alu_b_o, 32'd0);
      check("rst_alu_op", 32'(alu_op_o), 32'd0);
      rst_ni = 1'b1;
      idle(2);
      check("post_rst_rx_ready", 32'(rx_ready_o), 32'd1);

      // Basic add-style packet with delayed result
      push_alu(3'd0, 32'd5, 32'd7);
      push_res(32'h0000000C);
      send_pkt(8'h00, 32'd5, 32'd7);
      alu_respond(1'b0, 32'h0000000C);
      wait_done("basic");

      // Invalid opcode: single error byte, no ALU request
      e0 = err_cnt;
      exp_tx.push_back(8'hEE);
      send_pkt(8'h20, 32'h04030201, 32'h08070605);
      wait_done("badop");
      check("badop_err_pulses", 32'(err_cnt), 32'(e0 + 1));

      // Timeout after 3 bytes: still alive one cycle short, then aborted
      e0 = err_cnt;
      send_byte(8'h01);
      send_byte(8'h44);
      send_byte(8'h33);
      idle(TMO - 1);
      check("tmo_busy_before", 32'(busy_o), 32'd1);
      check("tmo_err_before", 32'(err_cnt), 32'(e0));
      idle(2);
      check("tmo_err_pulse", 32'(err_cnt), 32'(e0 + 1));
      check("tmo_busy_after", 32'(busy_o), 32'd0);
      check("tmo_rx_ready", 32'(rx_ready_o), 32'd1);
      push_alu(3'd1, 32'h11223344, 32'h01020304);
      push_res(32'hA5A5F00F);
      send_pkt(8'h01, 32'h11223344, 32'h01020304);
      alu_respond(1'b0, 32'hA5A5F00F);
      wait_done("post_tmo");

      // Byte landing on the expiry cycle is accepted, no timeout
      e0 = err_cnt;
      push_alu(3'd2, 32'h9ABC5678, 32'h0000FFFF);
      push_res(32'h12345678);
      send_byte(8'h02);
      send_byte(8'h78);
      idle(TMO - 1);
      send_byte(8'h56);
      send_byte(8'hBC);
      send_byte(8'h9A);
      for (int i = 0; i < 4; i++) send_byte(8'(32'h0000FFFF >> (8 * i)));
      alu_respond(1'b0, 32'h12345678);
      wait_done("tmo_edge");
      check("tmo_edge_no_err", 32'(err_cnt), 32'(e0));

      // Transmitter stalls 50 cycles on result byte 1
      tx_ready_i = 1'b0;
      push_alu(3'd3, 32'hFFFFFFFF, 32'h00000001);
      push_res(32'hCAFEBABE);
      send_pkt(8'h03, 32'hFFFFFFFF, 32'h00000001);
      alu_respond(1'b0, 32'hCAFEBABE);
      wait_tx_valid();
      tx_ready_i = 1'b1;
      idle(1);
      tx_ready_i = 1'b0;
      idle(50);
      check("stall_byte1_data", 32'(tx_data_o), 32'hBA);
      tx_ready_i = 1'b1;
      wait_done("stall");

      // Same-cycle accept and result
      push_alu(3'd7, 32'h0000DEAD, 32'h0000BEEF);
      push_res(32'hDEADBEEF);
      send_pkt(8'h07, 32'h0000DEAD, 32'h0000BEEF);
      alu_respond(1'b1, 32'hDEADBEEF);
      wait_done("same_cycle");

      // Reset during result byte 2 aborts the reply
      tx_ready_i = 1'b0;
      push_alu(3'd4, 32'h00000010, 32'h00000020);
      push_res(32'h44332211);
      send_pkt(8'h04, 32'h00000010, 32'h00000020);
      alu_respond(1'b0, 32'h44332211);
      wait_tx_valid();
      tx_ready_i = 1'b1;
      idle(2);
      tx_ready_i = 1'b0;
      check("pre_rst_byte2", 32'(tx_data_o), 32'h33);
      #2;
      rst_ni = 1'b0;
      #1;
      check("midrst_tx_valid", 32'(tx_valid_o), 32'd0);
      check("midrst_busy", 32'(busy_o), 32'd0);
      check("midrst_tx_data", 32'(tx_data_o), 32'd0);
      check("midrst_alu_a", alu_a_o, 32'd0);
      check("rst_dropped_bytes", 32'(exp_tx.size()), 32'd2);
      exp_tx.delete();
      idle(3);
      #3;
      rst_ni = 1'b1;
      tx_ready_i = 1'b1;
      idle(10);
      check("after_rst_rx_ready", 32'(rx_ready_o), 32'd1);
      check("after_rst_tx_valid", 32'(tx_valid_o), 32'd0);
      push_alu(3'd5, 32'hA0B0C0D0, 32'h01010101);
      push_res(32'h0BADF00D);
      send_pkt(8'h05, 32'hA0B0C0D0, 32'h01010101);
      alu_respond(1'b0, 32'h0BADF00D);
      wait_done("after_rst");

      idle(5);
      check("alu_queue_drained", 32'(exp_alu.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
